// File: rtl/gcd_core.sv
`timescale 1ns/1ps
// gcd_core: pops one packed operand pair {a, b} from an upstream FIFO,
// computes gcd(a, b) with a swap-subtract Euclid loop (one step per cycle)
// and pushes the result into a downstream FIFO.
//
// Ports:
//   CLK, RST          clock (posedge) and asynchronous active-low reset
//   IN_DATA           packed operands, a = upper half, b = lower half
//   IN_EMPTY_N/IN_DEQ upstream FIFO "has data" / pop strobe
//   OUT_DATA          registered result
//   OUT_FULL_N/OUT_ENQ downstream FIFO "has space" / push strobe
//   CLR               synchronous abort back to IDLE (data regs untouched)
//   BUSY              high while a pair is being processed or held for output
//   DONE_CNT          results enqueued since reset, wraps
//   DBG_STATE         current FSM state encoding, for observation only
//
// Handshake: a transfer happens on a posedge where the enable (IN_DEQ or
// OUT_ENQ) is high. Each enable is a combinational copy of its ready input
// (IN_EMPTY_N or OUT_FULL_N) in the one state allowed to transfer, is never
// high while that ready input is low, and is forced low by CLR or RST.
module gcd_core #(
  parameter int width     = 16,
  parameter int cnt_width = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2*width-1:0]     IN_DATA,
  input  logic                   IN_EMPTY_N,
  output logic                   IN_DEQ,
  output logic [width-1:0]       OUT_DATA,
  input  logic                   OUT_FULL_N,
  output logic                   OUT_ENQ,
  input  logic                   CLR,
  output logic                   BUSY,
  output logic [cnt_width-1:0]   DONE_CNT,
  output logic [1:0]             DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [width-1:0] a_reg;
  logic [width-1:0] b_reg;
  logic [width-1:0] res_reg;
  logic [cnt_width-1:0] cnt_reg;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake enables. RST gating keeps both enables low
  // for the whole time reset is held, even if upstream already has data.
  always_comb begin
    state_nxt = state;
    IN_DEQ    = 1'b0;
    OUT_ENQ   = 1'b0;
    if (CLR) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          IN_DEQ = IN_EMPTY_N & RST;
          if (IN_DEQ) state_nxt = S_BUSY;
        end
        S_BUSY: begin
          if (b_reg == '0) state_nxt = S_DONE;
        end
        S_DONE: begin
          OUT_ENQ = OUT_FULL_N & RST;
          if (OUT_ENQ) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: operand load, one Euclid step per BUSY cycle, result counter.
  // CLR freezes every data register for its cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt_reg <= '0;
    end else if (!CLR) begin
      case (state)
        S_IDLE: begin
          if (IN_DEQ) begin
            a_reg <= IN_DATA[2*width-1:width];
            b_reg <= IN_DATA[width-1:0];
          end
        end
        S_BUSY: begin
          if (b_reg == '0) begin
            res_reg <= a_reg;
          end else if (a_reg < b_reg) begin
            a_reg <= b_reg;
            b_reg <= a_reg;
          end else begin
            a_reg <= a_reg - b_reg;
          end
        end
        S_DONE: begin
          if (OUT_ENQ) cnt_reg <= cnt_reg + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign OUT_DATA  = res_reg;
  assign DONE_CNT  = cnt_reg;
  assign BUSY      = (state != S_IDLE);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_gcd_core.sv
`timescale 1ns/1ps
module tb_gcd_core;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IN_DATA;
  logic        IN_EMPTY_N;
  logic        IN_DEQ;
  logic [15:0] OUT_DATA;
  logic        OUT_FULL_N;
  logic        OUT_ENQ;
  logic        CLR;
  logic        BUSY;
  logic [15:0] DONE_CNT;
  logic [1:0]  DBG_STATE;

  // Narrow-counter copy sharing all inputs, used for wrap checks.
  logic        in_deq2;
  logic [15:0] out_data2;
  logic        out_enq2;
  logic        busy2;
  logic [1:0]  done_cnt2;
  logic [1:0]  dbg_state2;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [15:0] exp_q[$];

  gcd_core #(.width(16), .cnt_width(16)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_EMPTY_N(IN_EMPTY_N),
    .IN_DEQ(IN_DEQ), .OUT_DATA(OUT_DATA), .OUT_FULL_N(OUT_FULL_N),
    .OUT_ENQ(OUT_ENQ), .CLR(CLR), .BUSY(BUSY), .DONE_CNT(DONE_CNT),
    .DBG_STATE(DBG_STATE)
  );

  gcd_core #(.width(16), .cnt_width(2)) dut2 (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_EMPTY_N(IN_EMPTY_N),
    .IN_DEQ(in_deq2), .OUT_DATA(out_data2), .OUT_FULL_N(OUT_FULL_N),
    .OUT_ENQ(out_enq2), .CLR(CLR), .BUSY(busy2), .DONE_CNT(done_cnt2),
    .DBG_STATE(dbg_state2)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Reference model
  function automatic logic [15:0] ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[15:0];
  endfunction

  // BUSY cycles: one per swap, one per subtract, one for the final b==0 detect.
  function automatic int busy_cycles(input int unsigned a, input int unsigned b);
    int n = 1;
    int unsigned t;
    while (b != 0) begin
      if (a < b) begin t = a; a = b; b = t; end
      else a = a - b;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: starts just after a negedge in an IDLE cycle, ends just after
  // the negedge of the IDLE cycle following the ENQ.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input bit nxt_valid, input logic [31:0] nxt_data);
    int lat;
    bit bad;
    bit stall_bad;
    logic [15:0] exp;
    IN_DATA    = {a, b};
    IN_EMPTY_N = 1'b1;
    OUT_FULL_N = (hold == 0);
    #1 chk("deq_idle", IN_DEQ, 1);
    exp_q.push_back(ref_gcd(a, b));
    lat = busy_cycles(a, b);
    bad = 0;
    for (int n = 1; n <= lat; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        IN_DATA    = nxt_data;
        IN_EMPTY_N = nxt_valid;
      end
      #1;
      if (IN_DEQ !== 1'b0 || OUT_ENQ !== 1'b0 || BUSY !== 1'b1) bad = 1;
    end
    chk("busy_phase", bad, 0);
    @(negedge CLK); #1;
    stall_bad = 0;
    for (int h = 0; h < hold; h++) begin
      if (OUT_ENQ !== 1'b0 || OUT_DATA !== exp_q[0] || BUSY !== 1'b1 || IN_DEQ !== 1'b0)
        stall_bad = 1;
      @(negedge CLK); #1;
    end
    chk("stall_hold", stall_bad, 0);
    OUT_FULL_N = 1'b1;
    #1;
    exp = exp_q.pop_front();
    chk("enq", OUT_ENQ, 1);
    chk("result", OUT_DATA, exp);
    chk("no_deq_in_enq", IN_DEQ, 0);
    chk("cnt_before", DONE_CNT, model_cnt[15:0]);
    model_cnt++;
    @(negedge CLK); #1;
    chk("cnt_after", DONE_CNT, model_cnt[15:0]);
    chk("cnt2_after", done_cnt2, model_cnt % 4);
    chk("idle_busy", BUSY, 0);
    chk("idle_deq", IN_DEQ, nxt_valid);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int hold;
    RST = 1'b0; CLR = 1'b0; IN_EMPTY_N = 1'b0; OUT_FULL_N = 1'b1; IN_DATA = '0;
    #3;
    chk("rst_busy", BUSY, 0);
    chk("rst_deq", IN_DEQ, 0);
    chk("rst_enq", OUT_ENQ, 0);
    chk("rst_cnt", DONE_CNT, 0);
    chk("rst_data", OUT_DATA, 0);
    @(negedge CLK); RST = 1'b1; #1;

    // Directed pairs and special cases
    run_pair(16'd12, 16'd8, 0, 0, '0);
    run_pair(16'd0, 16'd0, 0, 0, '0);
    run_pair(16'd5, 16'd0, 0, 0, '0);
    run_pair(16'd0, 16'd7, 0, 0, '0);
    run_pair(16'd9, 16'd6, 10, 0, '0);

    // Back-to-back with upstream always non-empty
    run_pair(16'd65535, 16'd1, 0, 1, {16'd7, 16'd7});
    run_pair(16'd7, 16'd7, 0, 0, '0);

    // CLR on the third BUSY cycle of {100,75}
    IN_DATA = {16'd100, 16'd75}; IN_EMPTY_N = 1'b1;
    #1 chk("clr_deq", IN_DEQ, 1);
    @(negedge CLK); IN_EMPTY_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK); CLR = 1'b1;
    #1;
    chk("clr_cycle_enq", OUT_ENQ, 0);
    chk("clr_cycle_busy", BUSY, 1);
    @(negedge CLK); CLR = 1'b0; #1;
    chk("clr_idle", BUSY, 0);
    chk("clr_cnt", DONE_CNT, model_cnt[15:0]);
    // CLR together with upstream data in IDLE: no pop
    IN_DATA = {16'd21, 16'd14}; IN_EMPTY_N = 1'b1; CLR = 1'b1;
    #1 chk("clr_blocks_deq", IN_DEQ, 0);
    @(negedge CLK); CLR = 1'b0; #1;
    chk("clr_no_pop", BUSY, 0);
    run_pair(16'd21, 16'd14, 0, 0, '0);

    // Randomized pairs with occasional output back-pressure
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 150));
      rb = 16'($urandom_range(0, 150));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_pair(ra, rb, hold, 0, '0);
    end

    // Asynchronous reset mid-BUSY
    IN_DATA = {16'd200, 16'd3}; IN_EMPTY_N = 1'b1;
    #1 chk("rstmid_deq", IN_DEQ, 1);
    @(negedge CLK); IN_EMPTY_N = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_deq0", IN_DEQ, 0);
    chk("rstmid_enq", OUT_ENQ, 0);
    chk("rstmid_cnt", DONE_CNT, 0);
    chk("rstmid_cnt2", done_cnt2, 0);
    model_cnt = 0;
    exp_q.delete();
    @(negedge CLK); RST = 1'b1; #1;
    chk("rstmid_idle", BUSY, 0);

    // Four results wrap the 2-bit counter back to 0
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(1, 60));
      rb = 16'($urandom_range(0, 60));
      run_pair(ra, rb, 0, 0, '0);
    end
    chk("wrap_cnt2", done_cnt2, 0);
    chk("wrap_cnt", DONE_CNT, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
